// File: rtl/cnn_pkg.sv
// Shared types and constants for the 1-D convolution processing element.
package cnn_pkg;

   localparam int DATA_WIDTH            = 16;
   localparam int IFMAP_WIDTH           = 18;
   localparam int SOR_BIT               = 16;
   localparam int EOR_BIT               = 17;
   localparam int IF_ADDR_WIDTH         = 4;
   localparam int IF_PAD_LENGTH         = 12;
   localparam int IF_BUFFER_COLUMNS     = 12;
   localparam int FILTER_PAD_LENGTH     = 16;
   localparam int FILTER_BUFFER_COLUMNS = 16;
   localparam int RESULT_BUFFER_COLUMNS = 64;
   localparam int PSUM_PAD_LENGTH       = 16;
   localparam int MULT_WIDTH            = 32;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_F,
      S_WAIT_WIN,
      S_MAC,
      S_WRITE
   } pe_state_e;

   // Circular index into the ifmap scratchpad: (base + off) mod IF_PAD_LENGTH.
   function automatic logic [IF_ADDR_WIDTH-1:0] if_idx(input logic [IF_ADDR_WIDTH-1:0] base,
                                                       input logic [4:0] off);
      logic [5:0] sum;
      sum = {2'b00, base} + {1'b0, off};
      if (sum >= 6'(2 * IF_PAD_LENGTH))
         sum = sum - 6'(2 * IF_PAD_LENGTH);
      else if (sum >= 6'(IF_PAD_LENGTH))
         sum = sum - 6'(IF_PAD_LENGTH);
      return sum[IF_ADDR_WIDTH-1:0];
   endfunction

endpackage

// File: rtl/cnn_fifo.sv
// Circular FIFO with count-based full/empty; either side can be made rising-edge
// triggered so a held host request moves only one word.
module cnn_fifo
   import cnn_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int DEPTH   = 16,
   parameter bit EDGE_WR = 1'b0,
   parameter bit EDGE_RD = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_ack,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             wr_prev_q, rd_prev_q;
   logic             push, pop;

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign rd_data = mem_q[rd_ptr_q];
   assign rd_ack  = pop;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      push     = wr_en && !(EDGE_WR && wr_prev_q) && !full;
      pop      = rd_en && !(EDGE_RD && rd_prev_q) && !empty;
      if (push)
         wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      if (pop)
         rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (!reset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         wr_prev_q <= 1'b0;
         rd_prev_q <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         wr_prev_q <= wr_en;
         rd_prev_q <= rd_en;
      end
   end

   // NOTE: the storage array is not reset; its words are only read while the count marks them valid.
   always_ff @(posedge clk) begin
      if (push)
         mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/cnn_conv_pe.sv
// 1-D convolution PE: filter and ifmap stream in through FIFOs, one MAC computes
// strided dot products, results (optionally psum-accumulated) queue in a result FIFO.
module cnn_conv_pe
   import cnn_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [4:0]             stride,
   input  logic [4:0]             filter_size,
   input  logic                   psum_mode,
   output logic                   stall_signal,
   input  logic [IFMAP_WIDTH-1:0] IFmap_buffer_in,
   input  logic                   IFmap_buffer_write_enable,
   output logic                   IFmap_buffer_full,
   output logic                   IFmap_buffer_ready,
   input  logic [DATA_WIDTH-1:0]  filter_buffer_in,
   input  logic                   filter_buffer_write_enable,
   output logic                   filter_buffer_full,
   output logic                   filter_buffer_ready,
   output logic [DATA_WIDTH-1:0]  result_buffer_out,
   input  logic                   result_buffer_read_enable,
   output logic                   result_buffer_empty,
   output logic                   result_buffer_valid
);

   logic [IFMAP_WIDTH-1:0]   i_data;
   logic                     i_empty, i_rd_en, i_rd_ack;
   logic [DATA_WIDTH-1:0]    f_data;
   logic                     f_empty, f_rd_en, f_rd_ack;
   logic [DATA_WIDTH-1:0]    r_data, r_wr_data;
   logic                     r_full, r_wr_en, r_rd_ack;

   pe_state_e                state_q, state_d;
   logic [4:0]               stride_q, stride_d, fs_q, fs_d;
   logic [4:0]               f_cnt_q, f_cnt_d, win_cnt_q, win_cnt_d;
   logic [4:0]               skip_q, skip_d, tap_q, tap_d;
   logic [IF_ADDR_WIDTH-1:0] head_q, head_d;
   logic                     in_row_q, in_row_d, eor_q, eor_d;
   logic [MULT_WIDTH-1:0]    acc_q, acc_d;
   logic [3:0]               j_q, j_d;
   logic [DATA_WIDTH-1:0]    res_out_q, res_out_d;
   logic                     res_valid_q, res_valid_d;

   logic [DATA_WIDTH-1:0]    if_spad_q   [IF_PAD_LENGTH];
   logic [DATA_WIDTH-1:0]    flt_spad_q  [FILTER_PAD_LENGTH];
   logic [DATA_WIDTH-1:0]    psum_q      [PSUM_PAD_LENGTH];

   logic                     if_we, flt_we, psum_we, psum_clr, row_restart;
   logic [IF_ADDR_WIDTH-1:0] if_wa;
   logic [4:0]               f_next, win_next, drop;
   logic [DATA_WIDTH-1:0]    if_word, w_word, out_word, psum_sum;
   logic [MULT_WIDTH-1:0]    prod;

   cnn_fifo #(.WIDTH(IFMAP_WIDTH), .DEPTH(IF_BUFFER_COLUMNS), .EDGE_WR(1'b1), .EDGE_RD(1'b0)) u_if_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (IFmap_buffer_write_enable),
      .wr_data (IFmap_buffer_in),
      .rd_en   (i_rd_en),
      .rd_data (i_data),
      .rd_ack  (i_rd_ack),
      .full    (IFmap_buffer_full),
      .empty   (i_empty)
   );

   cnn_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FILTER_BUFFER_COLUMNS), .EDGE_WR(1'b1), .EDGE_RD(1'b0)) u_flt_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (filter_buffer_write_enable),
      .wr_data (filter_buffer_in),
      .rd_en   (f_rd_en),
      .rd_data (f_data),
      .rd_ack  (f_rd_ack),
      .full    (filter_buffer_full),
      .empty   (f_empty)
   );

   cnn_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(RESULT_BUFFER_COLUMNS), .EDGE_WR(1'b0), .EDGE_RD(1'b1)) u_res_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (r_wr_en),
      .wr_data (r_wr_data),
      .rd_en   (result_buffer_read_enable),
      .rd_data (r_data),
      .rd_ack  (r_rd_ack),
      .full    (r_full),
      .empty   (result_buffer_empty)
   );

   assign IFmap_buffer_ready  = !IFmap_buffer_full;
   assign filter_buffer_ready = !filter_buffer_full;
   assign result_buffer_out   = res_out_q;
   assign result_buffer_valid = res_valid_q;

   // Products are formed on sign-extended operands; the low 32 bits equal the signed product.
   assign if_word   = if_spad_q[if_idx(head_q, tap_q)];
   assign w_word    = flt_spad_q[tap_q[3:0]];
   assign prod      = {{16{if_word[15]}}, if_word} * {{16{w_word[15]}}, w_word};
   assign out_word  = acc_q[DATA_WIDTH-1:0];
   assign psum_sum  = psum_q[j_q] + out_word;
   assign r_wr_data = psum_mode ? psum_sum : out_word;

   always_comb begin
      state_d      = state_q;
      stride_d     = stride_q;
      fs_d         = fs_q;
      f_cnt_d      = f_cnt_q;
      win_cnt_d    = win_cnt_q;
      skip_d       = skip_q;
      tap_d        = tap_q;
      head_d       = head_q;
      in_row_d     = in_row_q;
      eor_d        = eor_q;
      acc_d        = acc_q;
      j_d          = j_q;
      i_rd_en      = 1'b0;
      f_rd_en      = 1'b0;
      r_wr_en      = 1'b0;
      stall_signal = 1'b0;
      if_we        = 1'b0;
      flt_we       = 1'b0;
      psum_we      = 1'b0;
      psum_clr     = 1'b0;
      row_restart  = 1'b0;
      if_wa        = if_idx(head_q, win_cnt_q);
      f_next       = f_cnt_q + 5'd1;
      win_next     = win_cnt_q + 5'd1;
      drop         = (stride_q > win_cnt_q) ? win_cnt_q : stride_q;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               stride_d    = stride;
               fs_d        = filter_size;
               psum_clr    = 1'b1;
               row_restart = 1'b1;
               state_d     = S_LOAD_F;
            end
         end
         S_LOAD_F: begin
            f_rd_en      = 1'b1;
            stall_signal = f_empty;
            if (f_rd_ack) begin
               flt_we  = 1'b1;
               f_cnt_d = f_next;
               if (f_next == fs_q)
                  state_d = S_WAIT_WIN;
            end
         end
         S_WAIT_WIN: begin
            if (win_cnt_q == fs_q) begin
               state_d = S_MAC;
               tap_d   = '0;
               acc_d   = '0;
            end else begin
               i_rd_en      = 1'b1;
               stall_signal = i_empty;
               // Words ahead of the first start-of-row flag never enter the window.
               if (i_rd_ack && (in_row_q || i_data[SOR_BIT])) begin
                  in_row_d = 1'b1;
                  if (skip_q != '0) begin
                     skip_d = skip_q - 5'd1;
                  end else begin
                     if_we     = 1'b1;
                     win_cnt_d = win_next;
                  end
                  if (skip_q == '0 && win_next == fs_q) begin
                     eor_d   = i_data[EOR_BIT];
                     state_d = S_MAC;
                     tap_d   = '0;
                     acc_d   = '0;
                  end else if (i_data[EOR_BIT]) begin
                     row_restart = 1'b1;
                     state_d     = S_LOAD_F;
                  end
               end
            end
         end
         S_MAC: begin
            acc_d = acc_q + prod;
            tap_d = tap_q + 5'd1;
            if (tap_q + 5'd1 == fs_q)
               state_d = S_WRITE;
         end
         S_WRITE: begin
            r_wr_en      = 1'b1;
            stall_signal = r_full;
            if (!r_full) begin
               psum_we   = psum_mode;
               j_d       = j_q + 4'd1;
               win_cnt_d = win_cnt_q - drop;
               skip_d    = stride_q - drop;
               head_d    = if_idx(head_q, drop);
               if (eor_q) begin
                  row_restart = 1'b1;
                  state_d     = S_LOAD_F;
               end else begin
                  state_d = S_WAIT_WIN;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (row_restart) begin
         f_cnt_d   = '0;
         win_cnt_d = '0;
         skip_d    = '0;
         head_d    = '0;
         in_row_d  = 1'b0;
         eor_d     = 1'b0;
         j_d       = '0;
      end

      res_out_d   = r_rd_ack ? r_data : res_out_q;
      res_valid_d = r_rd_ack;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         stride_q    <= '0;
         fs_q        <= '0;
         f_cnt_q     <= '0;
         win_cnt_q   <= '0;
         skip_q      <= '0;
         tap_q       <= '0;
         head_q      <= '0;
         in_row_q    <= 1'b0;
         eor_q       <= 1'b0;
         acc_q       <= '0;
         j_q         <= '0;
         res_out_q   <= '0;
         res_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         stride_q    <= stride_d;
         fs_q        <= fs_d;
         f_cnt_q     <= f_cnt_d;
         win_cnt_q   <= win_cnt_d;
         skip_q      <= skip_d;
         tap_q       <= tap_d;
         head_q      <= head_d;
         in_row_q    <= in_row_d;
         eor_q       <= eor_d;
         acc_q       <= acc_d;
         j_q         <= j_d;
         res_out_q   <= res_out_d;
         res_valid_q <= res_valid_d;
      end
   end

   always_ff @(posedge clk) begin
      if (if_we)
         if_spad_q[if_wa] <= i_data[DATA_WIDTH-1:0];
      if (flt_we)
         flt_spad_q[f_cnt_q[3:0]] <= f_data;
   end

   // Partial sums are architecturally visible, so they clear on reset and on start.
   always_ff @(posedge clk) begin
      if (!reset || psum_clr) begin
         for (int i = 0; i < PSUM_PAD_LENGTH; i++)
            psum_q[i] <= '0;
      end else if (psum_we) begin
         psum_q[j_q] <= psum_sum;
      end
   end

endmodule

// File: tb/tb_cnn_conv_pe.sv
// Directed bench for cnn_conv_pe; expected results are hand-computed dot products.
module tb_cnn_conv_pe;

   logic        clk;
   logic        reset;
   logic        start;
   logic [4:0]  stride;
   logic [4:0]  filter_size;
   logic        psum_mode;
   logic        stall_signal;
   logic [17:0] IFmap_buffer_in;
   logic        IFmap_buffer_write_enable;
   logic        IFmap_buffer_full;
   logic        IFmap_buffer_ready;
   logic [15:0] filter_buffer_in;
   logic        filter_buffer_write_enable;
   logic        filter_buffer_full;
   logic        filter_buffer_ready;
   logic [15:0] result_buffer_out;
   logic        result_buffer_read_enable;
   logic        result_buffer_empty;
   logic        result_buffer_valid;

   int n_checks = 0;
   int n_fail   = 0;

   cnn_conv_pe dut (
      .clk                        (clk),
      .reset                      (reset),
      .start                      (start),
      .stride                     (stride),
      .filter_size                (filter_size),
      .psum_mode                  (psum_mode),
      .stall_signal               (stall_signal),
      .IFmap_buffer_in            (IFmap_buffer_in),
      .IFmap_buffer_write_enable  (IFmap_buffer_write_enable),
      .IFmap_buffer_full          (IFmap_buffer_full),
      .IFmap_buffer_ready         (IFmap_buffer_ready),
      .filter_buffer_in           (filter_buffer_in),
      .filter_buffer_write_enable (filter_buffer_write_enable),
      .filter_buffer_full         (filter_buffer_full),
      .filter_buffer_ready        (filter_buffer_ready),
      .result_buffer_out          (result_buffer_out),
      .result_buffer_read_enable  (result_buffer_read_enable),
      .result_buffer_empty        (result_buffer_empty),
      .result_buffer_valid        (result_buffer_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #800000;
      $display("FAIL watchdog time limit reached checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      reset                      = 1'b0;
      start                      = 1'b0;
      stride                     = '0;
      filter_size                = '0;
      psum_mode                  = 1'b0;
      IFmap_buffer_in            = '0;
      IFmap_buffer_write_enable  = 1'b0;
      filter_buffer_in           = '0;
      filter_buffer_write_enable = 1'b0;
      result_buffer_read_enable  = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic pulse_if(input logic [17:0] w);
      IFmap_buffer_in           = w;
      IFmap_buffer_write_enable = 1'b1;
      @(negedge clk);
      IFmap_buffer_write_enable = 1'b0;
      @(negedge clk);
   endtask

   task automatic write_if(input logic [15:0] d, input logic sor, input logic eor);
      int n = 0;
      while (IFmap_buffer_full && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (IFmap_buffer_full)
         check("if_space", IFmap_buffer_full, 1'b0);
      pulse_if({eor, sor, d});
   endtask

   task automatic write_row_1_8();
      for (int i = 1; i <= 8; i++)
         write_if(16'(i), i == 1, i == 8);
   endtask

   task automatic write_flt(input logic [15:0] w);
      int n = 0;
      while (filter_buffer_full && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (filter_buffer_full)
         check("flt_space", filter_buffer_full, 1'b0);
      filter_buffer_in           = w;
      filter_buffer_write_enable = 1'b1;
      @(negedge clk);
      filter_buffer_write_enable = 1'b0;
      @(negedge clk);
   endtask

   task automatic do_start(input logic [4:0] s, input logic [4:0] fs, input logic pm);
      stride      = s;
      filter_size = fs;
      psum_mode   = pm;
      start       = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic read_result(input string tag, input logic [15:0] exp);
      int n = 0;
      while (result_buffer_empty && n < 600) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_avail"}, result_buffer_empty, 1'b0);
      if (!result_buffer_empty) begin
         result_buffer_read_enable = 1'b1;
         @(negedge clk);
         check({tag, "_valid"}, result_buffer_valid, 1'b1);
         check(tag, result_buffer_out, exp);
         result_buffer_read_enable = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic expect_drained(input string tag);
      repeat (60) @(negedge clk);
      check(tag, result_buffer_empty, 1'b1);
   endtask

   initial begin
      logic [15:0] exp_s2 [3];
      logic [15:0] exp_s1 [5];
      logic [15:0] exp_ps [4];
      exp_s2 = '{16'd10, 16'd18, 16'd26};
      exp_s1 = '{16'd10, 16'd14, 16'd18, 16'd22, 16'd26};
      exp_ps = '{16'd10, 16'd26, 16'd14, 16'd34};

      // Reset state
      do_reset();
      check("rst_stall", stall_signal, 1'b0);
      check("rst_if_full", IFmap_buffer_full, 1'b0);
      check("rst_if_ready", IFmap_buffer_ready, 1'b1);
      check("rst_flt_ready", filter_buffer_ready, 1'b1);
      check("rst_empty", result_buffer_empty, 1'b1);
      check("rst_valid", result_buffer_valid, 1'b0);
      check("rst_out", result_buffer_out, 16'h0000);

      // fs=4 stride=4, junk word ahead of start-of-row
      for (int i = 0; i < 4; i++) write_flt(16'd1);
      do_start(5'd4, 5'd4, 1'b0);
      write_if(16'd77, 1'b0, 1'b0);
      write_row_1_8();
      read_result("s4_r0", 16'd10);
      read_result("s4_r1", 16'd26);
      expect_drained("s4_drained");
      check("s4_stall_no_filter", stall_signal, 1'b1);
      result_buffer_read_enable = 1'b1;
      @(negedge clk);
      check("rd_empty_valid", result_buffer_valid, 1'b0);
      check("rd_empty_hold", result_buffer_out, 16'd26);
      result_buffer_read_enable = 1'b0;
      @(negedge clk);
      check("rd_empty_valid2", result_buffer_valid, 1'b0);

      // stride=2
      do_reset();
      for (int i = 0; i < 4; i++) write_flt(16'd1);
      do_start(5'd2, 5'd4, 1'b0);
      write_row_1_8();
      for (int i = 0; i < 3; i++) read_result($sformatf("s2_r%0d", i), exp_s2[i]);
      expect_drained("s2_drained");

      // stride=1
      do_reset();
      for (int i = 0; i < 4; i++) write_flt(16'd1);
      do_start(5'd1, 5'd4, 1'b0);
      write_row_1_8();
      for (int i = 0; i < 5; i++) read_result($sformatf("s1_r%0d", i), exp_s1[i]);
      expect_drained("s1_drained");

      // psum accumulation across two rows with different filters
      do_reset();
      for (int i = 0; i < 4; i++) write_flt(16'd1);
      write_flt(16'd0); write_flt(16'd0); write_flt(16'd0); write_flt(16'd1);
      do_start(5'd4, 5'd4, 1'b1);
      write_row_1_8();
      write_row_1_8();
      for (int i = 0; i < 4; i++) read_result($sformatf("ps_r%0d", i), exp_ps[i]);
      expect_drained("ps_drained");

      // signed product and 16-bit wrap
      do_reset();
      write_flt(16'hFFFF); write_flt(16'h0000); write_flt(16'h0000); write_flt(16'h0000);
      for (int i = 0; i < 4; i++) write_flt(16'h7FFF);
      do_start(5'd4, 5'd4, 1'b0);
      write_if(16'd5, 1'b1, 1'b0);
      write_if(16'd0, 1'b0, 1'b0);
      write_if(16'd0, 1'b0, 1'b0);
      write_if(16'd0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) write_if(16'h7FFF, i == 0, i == 3);
      read_result("neg", 16'hFFFB);
      read_result("wrap", 16'h0004);

      // ifmap FIFO fills at 12, 13th write dropped; fs=1 echoes each accepted word
      do_reset();
      for (int i = 1; i <= 12; i++) pulse_if({1'b0, i == 1, 16'(i)});
      check("full_flag", IFmap_buffer_full, 1'b1);
      check("full_ready", IFmap_buffer_ready, 1'b0);
      pulse_if({2'b00, 16'd99});
      check("full_after_drop", IFmap_buffer_full, 1'b1);
      write_flt(16'd1);
      do_start(5'd1, 5'd1, 1'b0);
      for (int i = 1; i <= 12; i++) read_result($sformatf("fill_r%0d", i), 16'(i));
      expect_drained("fill_drop13");
      check("fill_ready_again", IFmap_buffer_ready, 1'b1);
      IFmap_buffer_in           = {2'b00, 16'd50};
      IFmap_buffer_write_enable = 1'b1;
      repeat (2) @(negedge clk);
      IFmap_buffer_write_enable = 1'b0;
      @(negedge clk);
      read_result("hold_once", 16'd50);
      expect_drained("hold_no_dup");

      // reset while the second window is in MAC
      do_reset();
      for (int i = 0; i < 4; i++) write_flt(16'd1);
      do_start(5'd4, 5'd4, 1'b0);
      write_row_1_8();
      read_result("mid_r0", 16'd10);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("mid_stall", stall_signal, 1'b0);
      check("mid_if_full", IFmap_buffer_full, 1'b0);
      check("mid_if_ready", IFmap_buffer_ready, 1'b1);
      check("mid_empty", result_buffer_empty, 1'b1);
      check("mid_valid", result_buffer_valid, 1'b0);
      check("mid_out", result_buffer_out, 16'h0000);
      reset = 1'b1;
      expect_drained("mid_idle");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
